imem_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the single-cycle MIPS core's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into instruction memory at consecutive word addresses and verifies an 8-bit checksum.
- Holds the core in reset until a complete, checksum-valid image has been written.

---
 rtl/imem_loader.sv | 109 ++++++++++
 tb/tb_imem_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot loader streaming a checksummed big-endian image
// into instruction memory, holding the core in reset until it lands.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    HDR_HI, HDR_LO, LOAD, CHK, DONE, ERR
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state;
  state_t      state_nx;
  logic [15:0] count;
  logic [23:0] word;
  logic [1:0]  byte_idx;
  logic [7:0]  sum;
  logic        accept;
  logic        last_byte;
  logic [15:0] n_hdr;

  assign in_ready   = (state != DONE) && (state != ERR);
  assign accept     = in_valid && in_ready;
  assign last_byte  = (byte_idx == 2'd3);
  assign n_hdr      = {count[15:8], in_data};
  assign done       = (state == DONE);
  assign error      = (state == ERR);
  assign core_reset = (state != DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= HDR_HI;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (accept) begin
      unique case (state)
        HDR_HI: state_nx = HDR_LO;
        HDR_LO: begin
          if (n_hdr == 16'd0 || {1'b0, n_hdr} > MAX_W)
            state_nx = ERR;
          else
            state_nx = LOAD;
        end
        LOAD: begin
          if (last_byte && (words_loaded + 16'd1 == count))
            state_nx = CHK;
        end
        CHK: begin
          if (8'(sum + in_data) == 8'd0) state_nx = DONE;
          else                           state_nx = ERR;
        end
        default: state_nx = state;
      endcase
    end
  end

  // Write strobe is registered so the next word's bytes keep streaming.
  always_ff @(posedge clock) begin
    if (reset) begin
      count        <= '0;
      word         <= '0;
      byte_idx     <= '0;
      sum          <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        unique case (state)
          HDR_HI: count[15:8] <= in_data;
          HDR_LO: count[7:0]  <= in_data;
          LOAD: begin
            word     <= {word[15:0], in_data};
            sum      <= sum + in_data;
            byte_idx <= byte_idx + 2'd1;
            if (last_byte) begin
              mem_we       <= 1'b1;
              mem_addr     <= BASE_ADDR
                            + {14'd0, words_loaded, 2'b00};
              mem_wdata    <= {word, in_data};
              words_loaded <= words_loaded + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vectors for imem_loader, run against two
// instances differing only in BASE_ADDR (0x0 and 0x400).
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        rdy0, we0, crst0, done0, err0;
  logic [31:0] addr0, wd0;
  logic [15:0] wl0;
  logic        rdy1, we1, crst1, done1, err1;
  logic [31:0] addr1, wd1;
  logic [15:0] wl1;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clock = ~clock;

  imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(256)) u0 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
    .core_reset(crst0), .done(done0), .error(err0),
    .words_loaded(wl0)
  );

  imem_loader #(.BASE_ADDR(32'h400), .MAX_WORDS(256)) u1 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .core_reset(crst1), .done(done1), .error(err1),
    .words_loaded(wl1)
  );

  // Log every write strobe seen mid-cycle.
  always @(negedge clock) begin
    if (we0) q0.push_back({addr0, wd0});
    if (we1) q1.push_back({addr1, wd1});
  end

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_data = b;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({rdy0, we0, crst0, done0, err0} !== 5'b10100) begin
      $display("FAIL reset_flags0 got %b want 10100",
               {rdy0, we0, crst0, done0, err0});
      miscompares++;
    end
    vectors++;
    if ({addr0, wd0, wl0} !== 80'h0) begin
      $display("FAIL reset_regs0 got %h want 0", {addr0, wd0, wl0});
      miscompares++;
    end
    vectors++;
    if ({rdy1, we1, crst1, done1, err1, addr1, wd1, wl1}
        !== {5'b10100, 32'h400, 32'h0, 16'h0}) begin
      $display("FAIL reset_all1 got %b %h %h %h",
               {rdy1, we1, crst1, done1, err1}, addr1, wd1, wl1);
      miscompares++;
    end
  endtask

  task automatic test_single_word();
    logic [7:0] s[7];
    s = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'hD3};
    do_reset();
    foreach (s[i]) send(s[i], 0);
    vectors++;
    if (q0.size() != 1 || q0[0] !== {32'h0, 32'h20080005}) begin
      $display("FAIL single_write0 got n=%0d %h want 1 0000000020080005",
               q0.size(), q0.size() > 0 ? q0[0] : 64'h0);
      miscompares++;
    end
    vectors++;
    if (q1.size() != 1 || q1[0] !== {32'h400, 32'h20080005}) begin
      $display("FAIL single_write1 got n=%0d want 1 at 0x400",
               q1.size());
      miscompares++;
    end
    vectors++;
    if ({done0, crst0, rdy0, err0, wl0} !== {4'b1000, 16'd1}) begin
      $display("FAIL single_done got %b wl=%0d want 1000 wl=1",
               {done0, crst0, rdy0, err0}, wl0);
      miscompares++;
    end
  endtask

  task automatic test_after_done();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom_range(0, 255));
      @(posedge clock); #1;
      vectors++;
      if ({rdy0, we0, done0, crst0, rdy1, we1, done1, crst1}
          !== 8'b0010_0010) begin
        $display("FAIL after_done cyc %0d got %b want 00100010", i,
                 {rdy0, we0, done0, crst0, rdy1, we1, done1, crst1});
        miscompares++;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (q0.size() + q1.size() != 0) begin
      $display("FAIL after_done_writes got %0d want 0",
               q0.size() + q1.size());
      miscompares++;
    end
  endtask

  // Checksum is the two's complement of the data-byte sum: 0x18 -> 0xE8.
  task automatic two_word_image(input logic [7:0] c, input int gap);
    logic [7:0] s[11];
    s = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
          8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    s[10] = c;
    do_reset();
    foreach (s[i]) send(s[i], gap);
    @(posedge clock); #1;
  endtask

  task automatic test_two_words();
    two_word_image(8'hE8, 1);
    vectors++;
    if (q1.size() != 2 || q1[0] !== {32'h400, 32'h01020304}
        || q1[1] !== {32'h404, 32'hAABBCCDD}) begin
      $display("FAIL two_writes1 got n=%0d want 400/01020304 404/AABBCCDD",
               q1.size());
      miscompares++;
    end
    vectors++;
    if (q0.size() != 2 || q0[1] !== {32'h4, 32'hAABBCCDD}) begin
      $display("FAIL two_writes0 got n=%0d want 2 ending 4/AABBCCDD",
               q0.size());
      miscompares++;
    end
    vectors++;
    if ({done1, err1, crst1, rdy1, wl1} !== {4'b1000, 16'd2}) begin
      $display("FAIL two_done got %b wl=%0d want 1000 wl=2",
               {done1, err1, crst1, rdy1}, wl1);
      miscompares++;
    end
  endtask

  task automatic test_bad_checksum();
    two_word_image(8'hE9, 0);
    vectors++;
    if (q0.size() != 2 || q0[0] !== {32'h0, 32'h01020304}) begin
      $display("FAIL badsum_writes got n=%0d want 2", q0.size());
      miscompares++;
    end
    vectors++;
    if ({err0, done0, crst0, rdy0} !== 4'b1010) begin
      $display("FAIL badsum_flags got %b want 1010",
               {err0, done0, crst0, rdy0});
      miscompares++;
    end
  endtask

  task automatic test_bad_header();
    logic [15:0] hdr[2];
    hdr = '{16'h0000, 16'h0101};
    foreach (hdr[i]) begin
      do_reset();
      send(hdr[i][15:8], 0);
      send(hdr[i][7:0], 0);
      vectors++;
      if ({err0, done0, crst0, rdy0, err1} !== 5'b10101) begin
        $display("FAIL bad_header %h got %b want 10101", hdr[i],
                 {err0, done0, crst0, rdy0, err1});
        miscompares++;
      end
      send(8'h55, 2);
      vectors++;
      if (q0.size() + q1.size() != 0 || wl0 !== 16'd0) begin
        $display("FAIL bad_header_we %h got n=%0d wl=%0d want 0 0",
                 hdr[i], q0.size() + q1.size(), wl0);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] s[6];
    logic [7:0] img[7];
    s = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
    img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'hEC};
    do_reset();
    foreach (s[i]) send(s[i], 0);
    do_reset();
    vectors++;
    if ({rdy1, we1, crst1, done1, err1, addr1, wd1, wl1}
        !== {5'b10100, 32'h400, 32'h0, 16'h0}) begin
      $display("FAIL midload_reset got %b %h %h %h",
               {rdy1, we1, crst1, done1, err1}, addr1, wd1, wl1);
      miscompares++;
    end
    foreach (img[i]) send(img[i], 0);
    vectors++;
    if (q1.size() != 1 || q1[0] !== {32'h400, 32'h12345678}) begin
      $display("FAIL midload_write got n=%0d want 1 at 400/12345678",
               q1.size());
      miscompares++;
    end
    vectors++;
    if ({done0, crst0, err0, wl0} !== {3'b100, 16'd1}) begin
      $display("FAIL midload_done got %b wl=%0d want 100 wl=1",
               {done0, crst0, err0}, wl0);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_after_done();
    test_two_words();
    test_bad_checksum();
    test_bad_header();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
